// File: rtl/register_file_if.sv
// Register file bus: one byte-strobed write port, two combinational read ports,
// and the bulk-clear request/busy pair.
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                    reg_write;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic [ADDR_WIDTH-1:0]   raddr_a;
  logic [DATA_WIDTH-1:0]   rdata_a;
  logic [ADDR_WIDTH-1:0]   raddr_b;
  logic [DATA_WIDTH-1:0]   rdata_b;
  logic                    clear_req;
  logic                    busy;

  modport master (
    output reg_write, waddr, wdata, wstrb, raddr_a, raddr_b, clear_req,
    input  rdata_a, rdata_b, busy
  );

  modport slave (
    input  reg_write, waddr, wdata, wstrb, raddr_a, raddr_b, clear_req,
    output rdata_a, rdata_b, busy
  );
endinterface

// File: rtl/register_file.sv
// Parametrised GPR file: byte-strobed write, two combinational read ports with
// optional write-through bypass, optional hard-wired zero entry, and a
// sequenced bulk clear that walks one entry per cycle while busy is high.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  register_file_if.slave  bus
);
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int NPORTS = 2;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t                              r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]               r_ptr, w_ptr_nxt;
  logic                                r_busy, w_busy_nxt;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]    r_mem;

  logic                                w_wr_en;
  logic [DATA_WIDTH-1:0]               w_wold;
  logic [DATA_WIDTH-1:0]               w_wmerge;
  logic [NPORTS-1:0][ADDR_WIDTH-1:0]   w_raddr;
  logic [NPORTS-1:0][DATA_WIDTH-1:0]   w_rdata;

  // A write is accepted only outside the clear sequence and never to the zero entry.
  assign w_wr_en = bus.reg_write && !r_busy &&
                   !((ZERO_REG != 0) && (bus.waddr == '0));

  // Merge strobed bytes over the current contents; this value is both what
  // gets stored and what the bypass path forwards.
  assign w_wold = r_mem[bus.waddr];
  for (genvar b = 0; b < NBYTES; b++) begin : g_byte
    assign w_wmerge[8*b +: 8] = bus.wstrb[b] ? bus.wdata[8*b +: 8] : w_wold[8*b +: 8];
  end

  // Read ports are identical; zero entry wins over bypass, bypass wins over storage.
  assign w_raddr[0] = bus.raddr_a;
  assign w_raddr[1] = bus.raddr_b;
  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    assign w_rdata[p] = ((ZERO_REG != 0) && (w_raddr[p] == '0))                ? '0       :
                        ((BYPASS != 0) && w_wr_en && (w_raddr[p] == bus.waddr)) ? w_wmerge :
                                                                                  r_mem[w_raddr[p]];
  end

  assign bus.rdata_a = w_rdata[0];
  assign bus.rdata_b = w_rdata[1];
  assign bus.busy    = r_busy;

  // Storage: the clear walk owns the array while busy, otherwise the write port does.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mem <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_en) begin
      r_mem[bus.waddr] <= w_wmerge;
    end
  end

  // Clear sequencer state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Clear sequencer next state: one entry per cycle, stop after the last entry.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_busy_nxt  = r_busy;
    case (r_state)
      ST_IDLE: begin
        if (bus.clear_req) begin
          w_state_nxt = ST_CLEAR;
          w_ptr_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (r_ptr == {ADDR_WIDTH{1'b1}}) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end else begin
          w_ptr_nxt   = r_ptr + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ptr_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end
endmodule
